// File: rtl/instruction_queue.sv
// rtl/instruction_queue.sv - byte-granular prefetch queue feeding a 16-byte decode window
// Optional illegal-use checking is enabled by defining INSTRUCTION_QUEUE_CHECK_EN.
module instruction_queue #(
  parameter int DEPTH       = 32,
  parameter int FETCH_BYTES = 4
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_flush,
  input  logic        i_fetch_valid,
  output logic        o_fetch_ready,
  input  logic [31:0] i_fetch_data,
  input  logic [1:0]  i_fetch_skip,
  output logic [7:0]  o_instruction [0:15],
  output logic [4:0]  o_valid_count,
  input  logic        i_consume_valid,
  input  logic [3:0]  i_consume_count,
  output logic        o_error
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem_q [DEPTH];

  logic          accept;
  logic [2:0]    acc_n;
  logic [4:0]    cons_n;
  logic [4:0]    cc_ext;
  logic          illegal;
  logic [CW-1:0] space;
  logic [3:0]    wr_en;
  logic [AW-1:0] wr_idx [4];

  // Readiness is judged on registered occupancy only, never on a same-cycle consume.
  always_comb begin
    space         = CW'(DEPTH) - count_q;
    o_fetch_ready = (space >= CW'(FETCH_BYTES));
    o_valid_count = (count_q > CW'(16)) ? 5'd16 : count_q[4:0];
  end

  always_comb begin
    accept  = i_fetch_valid & o_fetch_ready & ~i_flush;
    acc_n   = accept ? (3'(FETCH_BYTES) - {1'b0, i_fetch_skip}) : 3'd0;
    cc_ext  = {1'b0, i_consume_count};
    illegal = (i_consume_count == 4'd0) || (cc_ext > o_valid_count);
`ifdef INSTRUCTION_QUEUE_CHECK_EN
    cons_n  = (i_consume_valid & ~i_flush & ~illegal) ? cc_ext : 5'd0;
`else
    // Over-long consumes are clamped so the pointers can never pass each other.
    if (i_consume_valid & ~i_flush) begin
      cons_n = (cc_ext > o_valid_count) ? o_valid_count : cc_ext;
    end else begin
      cons_n = 5'd0;
    end
`endif
  end

  always_comb begin
    if (i_flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      rd_ptr_d = rd_ptr_q + AW'(cons_n);
      wr_ptr_d = wr_ptr_q + AW'(acc_n);
      count_d  = count_q + CW'(acc_n) - CW'(cons_n);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Skipped low bytes are dropped; the surviving bytes pack from wr_ptr upward.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      wr_en[i]  = accept && (3'(i) >= {1'b0, i_fetch_skip});
      wr_idx[i] = wr_ptr_q + AW'(i) - AW'(i_fetch_skip);
    end
  end

  always_ff @(posedge i_clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_en[i]) begin
        mem_q[wr_idx[i]] <= i_fetch_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 16; k++) begin
      o_instruction[k] = (5'(k) < o_valid_count) ? mem_q[rd_ptr_q + AW'(k)] : 8'h00;
    end
  end

`ifdef INSTRUCTION_QUEUE_CHECK_EN
  logic error_q, error_d;

  always_comb begin
    if (i_flush) begin
      error_d = 1'b0;
    end else begin
      error_d = error_q | (i_consume_valid & illegal) | (i_fetch_valid & ~o_fetch_ready);
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign o_error = error_q;
`else
  assign o_error = 1'b0;
`endif

endmodule

// File: tb/tb_instruction_queue.sv
// tb/tb_instruction_queue.sv - directed table plus randomized model check of instruction_queue
module tb_instruction_queue;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        flush = 1'b0;
  logic        fv = 1'b0;
  logic        fready;
  logic [31:0] fdata = '0;
  logic [1:0]  fskip = '0;
  logic [7:0]  win [0:15];
  logic [4:0]  vcount;
  logic        cv = 1'b0;
  logic [3:0]  cc = '0;
  logic        err;

  int n_vec = 0;
  int n_bad = 0;

  byte unsigned mq[$];
  bit           merr = 1'b0;

  typedef struct {
    bit          flush;
    bit          fv;
    logic [31:0] data;
    logic [1:0]  skip;
    bit          cv;
    logic [3:0]  cc;
    int          evc;
    bit          erdy;
    logic [7:0]  eb0;
    bit          eerr;
  } vec_t;

  vec_t tbl[$];

  instruction_queue #(.DEPTH(DEPTH), .FETCH_BYTES(4)) dut (
    .i_clk           (clk),
    .i_reset_n       (rst_n),
    .i_flush         (flush),
    .i_fetch_valid   (fv),
    .o_fetch_ready   (fready),
    .i_fetch_data    (fdata),
    .i_fetch_skip    (fskip),
    .o_instruction   (win),
    .o_valid_count   (vcount),
    .i_consume_valid (cv),
    .i_consume_count (cc),
    .o_error         (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic void model_step(input bit fl, input bit v, input logic [31:0] d,
                                     input logic [1:0] sk, input bit c, input logic [3:0] n);
    int sz  = mq.size();
    int vc  = (sz > 16) ? 16 : sz;
    bit rdy = (DEPTH - sz) >= 4;
    int k;
    if (fl) begin
      mq.delete();
      merr = 1'b0;
      return;
    end
    if (c) begin
      k = int'(n);
`ifdef INSTRUCTION_QUEUE_CHECK_EN
      if (k == 0 || k > vc) begin
        merr = 1'b1;
        k = 0;
      end
`else
      if (k > vc) k = vc;
`endif
      repeat (k) void'(mq.pop_front());
    end
`ifdef INSTRUCTION_QUEUE_CHECK_EN
    if (v && !rdy) merr = 1'b1;
`endif
    if (v && rdy) begin
      for (int i = int'(sk); i < 4; i++) mq.push_back(d[8*i +: 8]);
    end
  endfunction

  task automatic check_model(input string tag);
    int sz = mq.size();
    chk({tag, ".valid_count"}, int'(vcount), (sz > 16) ? 16 : sz);
    chk({tag, ".fetch_ready"}, int'(fready), int'((DEPTH - sz) >= 4));
    chk({tag, ".error"}, int'(err), int'(merr));
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("%s.win[%0d]", tag, k), int'(win[k]), (k < sz) ? int'(mq[k]) : 0);
    end
  endtask

  task automatic step(input bit fl, input bit v, input logic [31:0] d, input logic [1:0] sk,
                      input bit c, input logic [3:0] n, input string tag);
    flush = fl; fv = v; fdata = d; fskip = sk; cv = c; cc = n;
    model_step(fl, v, d, sk, c, n);
    @(posedge clk);
    @(negedge clk);
    check_model(tag);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, ".valid_count"}, int'(vcount), 0);
    chk({tag, ".fetch_ready"}, int'(fready), 1);
    chk({tag, ".error"}, int'(err), 0);
    for (int k = 0; k < 16; k++) chk($sformatf("%s.win[%0d]", tag, k), int'(win[k]), 0);
  endtask

  initial begin
    tbl.push_back('{0, 1, 32'h03020100, 0, 0, 0,  4, 1, 8'h00, 0});
    tbl.push_back('{0, 1, 32'h07060504, 0, 0, 0,  8, 1, 8'h00, 0});
    tbl.push_back('{0, 1, 32'h0B0A0908, 0, 0, 0, 12, 1, 8'h00, 0});
    tbl.push_back('{0, 1, 32'h0F0E0D0C, 0, 0, 0, 16, 1, 8'h00, 0});
    tbl.push_back('{1, 0, 32'h0,        0, 0, 0,  0, 1, 8'h00, 0});
    tbl.push_back('{0, 1, 32'hAA998877, 3, 0, 0,  1, 1, 8'hAA, 0});
    tbl.push_back('{0, 1, 32'h44332211, 0, 0, 0,  5, 1, 8'hAA, 0});
    tbl.push_back('{0, 1, 32'h57565554, 1, 0, 0,  8, 1, 8'hAA, 0});
    tbl.push_back('{0, 1, 32'h63626160, 0, 0, 0, 12, 1, 8'hAA, 0});
    tbl.push_back('{0, 1, 32'h67666564, 0, 0, 0, 16, 1, 8'hAA, 0});
    tbl.push_back('{0, 1, 32'h6B6A6968, 0, 0, 0, 16, 1, 8'hAA, 0});
    tbl.push_back('{0, 1, 32'h6F6E6D6C, 0, 0, 0, 16, 1, 8'hAA, 0});
    tbl.push_back('{0, 1, 32'h73727170, 0, 0, 0, 16, 1, 8'hAA, 0});
    tbl.push_back('{0, 1, 32'h77767574, 0, 0, 0, 16, 0, 8'hAA, 0});
    tbl.push_back('{0, 0, 32'h0,        0, 1, 3, 16, 0, 8'h33, 0});
    tbl.push_back('{0, 0, 32'h0,        0, 1, 1, 16, 1, 8'h44, 0});
    tbl.push_back('{0, 1, 32'h83828180, 0, 0, 0, 16, 0, 8'h44, 0});
    tbl.push_back('{0, 0, 32'h0,        0, 1, 15, 16, 1, 8'h6B, 0});
    tbl.push_back('{0, 0, 32'h0,        0, 1, 15,  2, 1, 8'h82, 0});
    tbl.push_back('{1, 0, 32'h0,        0, 0, 0,  0, 1, 8'h00, 0});
    tbl.push_back('{0, 1, 32'h03020100, 2, 0, 0,  2, 1, 8'h02, 0});
    tbl.push_back('{0, 1, 32'h07060504, 0, 0, 0,  6, 1, 8'h02, 0});
    tbl.push_back('{0, 1, 32'h0B0A0908, 0, 0, 0, 10, 1, 8'h02, 0});
    tbl.push_back('{0, 1, 32'h0F0E0D0C, 0, 1, 2, 12, 1, 8'h04, 0});
    tbl.push_back('{1, 0, 32'h0,        0, 0, 0,  0, 1, 8'h00, 0});
    tbl.push_back('{0, 1, 32'h13121110, 0, 0, 0,  4, 1, 8'h10, 0});
    tbl.push_back('{0, 1, 32'h17161514, 3, 0, 0,  5, 1, 8'h10, 0});
`ifdef INSTRUCTION_QUEUE_CHECK_EN
    tbl.push_back('{0, 0, 32'h0,        0, 1, 6,  5, 1, 8'h10, 1});
`else
    tbl.push_back('{0, 0, 32'h0,        0, 1, 6,  0, 1, 8'h00, 0});
`endif
    tbl.push_back('{1, 0, 32'h0,        0, 0, 0,  0, 1, 8'h00, 0});

    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].flush, tbl[i].fv, tbl[i].data, tbl[i].skip, tbl[i].cv, tbl[i].cc,
           $sformatf("tbl%0d", i));
      chk($sformatf("tbl%0d.exp_vc", i), int'(vcount), tbl[i].evc);
      chk($sformatf("tbl%0d.exp_rdy", i), int'(fready), int'(tbl[i].erdy));
      chk($sformatf("tbl%0d.exp_b0", i), int'(win[0]), int'(tbl[i].eb0));
      chk($sformatf("tbl%0d.exp_err", i), int'(err), int'(tbl[i].eerr));
      if (i == 3) begin
        for (int k = 0; k < 16; k++) chk($sformatf("ramp[%0d]", k), int'(win[k]), k);
      end
    end

    for (int t = 0; t < 3000; t++) begin
      bit          r_fl = ($urandom_range(0, 99) < 3);
      bit          r_fv = ($urandom_range(0, 99) < 75);
      logic [31:0] r_d  = $urandom;
      logic [1:0]  r_sk = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      bit          r_cv = ($urandom_range(0, 99) < 55);
      logic [3:0]  r_cc = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(0, 15))
                                                       : 4'($urandom_range(1, 6));
      step(r_fl, r_fv, r_d, r_sk, r_cv, r_cc, $sformatf("rnd%0d", t));
    end

    step(0, 1, 32'hDEADBEEF, 0, 0, 0, "pre_reset");
    step(0, 1, 32'hCAFEF00D, 0, 0, 0, "pre_reset2");
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals("async_reset");
    mq.delete();
    merr = 1'b0;
    @(posedge clk);
    #1;
    check_reset_vals("reset_held");
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 1, 32'h33221100, 0, 0, 0, "first_after_reset");
    chk("first_after_reset.vc4", int'(vcount), 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
